// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue
//   Instruction fetch front end. Owns the fetch PC, issues reads on the
//   synchronous instruction port of the memory, and buffers each returned
//   instruction together with its address+1 in a small FIFO. The head entry
//   is offered to decode over a valid/ready handshake. A flush empties the
//   queue, drops any read in flight and restarts fetch at flush_pc.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-high; clears all state
//   flush        redirect request; flush_pc is sampled while it is high
//   flush_pc     new fetch address
//   dec_ready    decode accepts the head entry
//   dec_valid    head entry valid
//   dec_instr    head instruction
//   dec_pc_next  head instruction address + 1
//   imem_addr    instruction read address (= fetch_pc)
//   imem_rden    read issue strobe
//   imem_q       read data, valid the cycle after imem_rden
//   fetch_pc     next address to be issued
//   count        occupied queue entries
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 8,
  parameter int unsigned IW    = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [AW-1:0]                flush_pc,
  input  logic                         dec_ready,
  output logic                         dec_valid,
  output logic [IW-1:0]                dec_instr,
  output logic [AW-1:0]                dec_pc_next,
  output logic [AW-1:0]                imem_addr,
  output logic                         imem_rden,
  input  logic [IW-1:0]                imem_q,
  output logic [AW-1:0]                fetch_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [IW-1:0] instr_store [DEPTH];
  logic [AW-1:0] pcn_store   [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          inflight;
  logic [AW-1:0] ret_addr;
  logic [AW-1:0] fetch_pc_q;

  logic [CW:0]   occupancy;
  logic          has_space;
  logic          issue;
  logic          enq;
  logic          deq;

  // An in-flight read already owns a slot, so it counts against space.
  // The check uses the current count only: a dequeue in the same cycle
  // does not open room for an issue until the following cycle.
  assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight};
  assign has_space = occupancy < (CW+1)'(DEPTH);
  assign issue     = !reset && !flush && has_space;

  assign dec_valid   = (count_q != '0);
  assign dec_instr   = instr_store[rd_ptr];
  assign dec_pc_next = pcn_store[rd_ptr];
  assign imem_addr   = fetch_pc_q;
  assign imem_rden   = issue;
  assign fetch_pc    = fetch_pc_q;
  assign count       = count_q;

  // Returning data and handshakes are ignored in a flush cycle.
  assign enq = inflight && !flush;
  assign deq = dec_valid && dec_ready && !flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= '0;
      inflight   <= 1'b0;
      ret_addr   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
    end else if (flush) begin
      fetch_pc_q <= flush_pc;
      inflight   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc_q <= fetch_pc_q + AW'(1);
        ret_addr   <= fetch_pc_q;
      end
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage holds no reset value; entries are only observed once written.
  always_ff @(posedge clock) begin
    if (!reset && enq) begin
      instr_store[wr_ptr] <= imem_q;
      pcn_store[wr_ptr]   <= ret_addr + AW'(1);
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue
//   Directed bench for fetch_prefetch_queue with a synchronous instruction
//   memory model holding mem[a] = 8'hA0 + a.
module tb_fetch_prefetch_queue;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] flush_pc = '0;
  logic       dec_ready = 1'b0;
  logic       dec_valid;
  logic [7:0] dec_instr;
  logic [7:0] dec_pc_next;
  logic [7:0] imem_addr;
  logic       imem_rden;
  logic [7:0] imem_q = '0;
  logic [7:0] fetch_pc;
  logic [2:0] count;

  logic [7:0] mem [256];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  fetch_prefetch_queue #(.DEPTH(4), .AW(8), .IW(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .dec_ready   (dec_ready),
    .dec_valid   (dec_valid),
    .dec_instr   (dec_instr),
    .dec_pc_next (dec_pc_next),
    .imem_addr   (imem_addr),
    .imem_rden   (imem_rden),
    .imem_q      (imem_q),
    .fetch_pc    (fetch_pc),
    .count       (count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (imem_rden) imem_q <= mem[imem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(8'hA0 + i);

    // 1: reset state, latency, streaming
    dec_ready = 1'b1;
    repeat (2) step();
    chk("rst_valid", 32'(dec_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_rden", 32'(imem_rden), 0);
    chk("rst_fpc", 32'(fetch_pc), 0);
    reset = 1'b0;
    #1;
    chk("t1_c1_rden", 32'(imem_rden), 1);
    chk("t1_c1_addr", 32'(imem_addr), 0);
    step();
    chk("t1_c2_addr", 32'(imem_addr), 1);
    chk("t1_c2_valid", 32'(dec_valid), 0);
    step();
    chk("t1_c3_valid", 32'(dec_valid), 1);
    chk("t1_c3_instr", 32'(dec_instr), 32'hA0);
    chk("t1_c3_pcn", 32'(dec_pc_next), 1);
    step();
    chk("t1_c4_instr", 32'(dec_instr), 32'hA1);
    chk("t1_c4_pcn", 32'(dec_pc_next), 2);
    step();
    chk("t1_c5_instr", 32'(dec_instr), 32'hA2);
    chk("t1_c5_pcn", 32'(dec_pc_next), 3);

    // 2: fill with decode stalled, then resume
    dec_ready = 1'b0;
    do_reset();
    repeat (4) step();
    chk("t2_c5_count", 32'(count), 3);
    chk("t2_c5_rden", 32'(imem_rden), 0);
    step();
    chk("t2_full_count", 32'(count), 4);
    chk("t2_full_rden", 32'(imem_rden), 0);
    chk("t2_full_fpc", 32'(fetch_pc), 4);
    chk("t2_full_instr", 32'(dec_instr), 32'hA0);
    dec_ready = 1'b1;
    #1;
    chk("t2_holdoff_rden", 32'(imem_rden), 0);
    step();
    chk("t2_resume_count", 32'(count), 3);
    chk("t2_resume_rden", 32'(imem_rden), 1);
    chk("t2_resume_addr", 32'(imem_addr), 4);
    chk("t2_instr1", 32'(dec_instr), 32'hA1);
    step();
    chk("t2_instr2", 32'(dec_instr), 32'hA2);
    step();
    chk("t2_instr3", 32'(dec_instr), 32'hA3);
    step();
    chk("t2_instr4", 32'(dec_instr), 32'hA4);

    // 3: flush while a read is in flight
    dec_ready = 1'b0;
    do_reset();
    repeat (4) step();
    flush = 1'b1;
    flush_pc = 8'h40;
    #1;
    chk("t3_flush_rden", 32'(imem_rden), 0);
    step();
    flush = 1'b0;
    #1;
    chk("t3_count", 32'(count), 0);
    chk("t3_valid", 32'(dec_valid), 0);
    chk("t3_rden", 32'(imem_rden), 1);
    chk("t3_addr", 32'(imem_addr), 32'h40);
    dec_ready = 1'b1;
    step();
    chk("t3_valid2", 32'(dec_valid), 0);
    step();
    chk("t3_instr", 32'(dec_instr), 32'hE0);
    chk("t3_pcn", 32'(dec_pc_next), 32'h41);

    // 4: address wrap
    flush = 1'b1;
    flush_pc = 8'hFE;
    step();
    flush = 1'b0;
    #1;
    chk("t4_addr_fe", 32'(imem_addr), 32'hFE);
    step();
    chk("t4_addr_ff", 32'(imem_addr), 32'hFF);
    step();
    chk("t4_addr_00", 32'(imem_addr), 32'h00);
    chk("t4_instr_fe", 32'(dec_instr), 32'h9E);
    chk("t4_pcn_ff", 32'(dec_pc_next), 32'hFF);
    step();
    chk("t4_instr_ff", 32'(dec_instr), 32'h9F);
    chk("t4_pcn_00", 32'(dec_pc_next), 32'h00);
    step();
    chk("t4_instr_00", 32'(dec_instr), 32'hA0);
    chk("t4_pcn_01", 32'(dec_pc_next), 32'h01);

    // 5: simultaneous enqueue and dequeue
    dec_ready = 1'b0;
    flush = 1'b1;
    flush_pc = 8'h10;
    step();
    flush = 1'b0;
    #1;
    repeat (3) step();
    chk("t5_count2", 32'(count), 2);
    chk("t5_head0", 32'(dec_instr), 32'hB0);
    dec_ready = 1'b1;
    step();
    chk("t5_count_hold", 32'(count), 2);
    chk("t5_head1", 32'(dec_instr), 32'hB1);
    dec_ready = 1'b0;
    step();
    chk("t5_count3", 32'(count), 3);
    chk("t5_head1_stable", 32'(dec_instr), 32'hB1);
    dec_ready = 1'b1;
    step();
    chk("t5_head2", 32'(dec_instr), 32'hB2);
    step();
    chk("t5_head3", 32'(dec_instr), 32'hB3);

    // 6: asynchronous reset between edges
    reset = 1'b1;
    #1;
    chk("t6_valid", 32'(dec_valid), 0);
    chk("t6_count", 32'(count), 0);
    chk("t6_fpc", 32'(fetch_pc), 0);
    chk("t6_rden_rst", 32'(imem_rden), 0);
    reset = 1'b0;
    #1;
    chk("t6_rden", 32'(imem_rden), 1);
    chk("t6_addr", 32'(imem_addr), 0);
    repeat (2) step();
    chk("t6_restart_valid", 32'(dec_valid), 1);
    chk("t6_restart_instr", 32'(dec_instr), 32'hA0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
